seq_divide: RTL

Multi-cycle, parametrised integer divider for the mini CPU execute stage, replacing single-evaluation combinational division. It computes one quotient bit per clock with a registered non-restoring datapath. It supports signed and unsigned operands, detects divide-by-zero, and talks to the issuing stage through a start/busy/done handshake.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 23 ++
 rtl/seq_divide.sv | 121 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  // Fill bit for the divide-by-zero quotient (all ones).
  localparam logic DBZ_FILL = 1'b1;

  // Iteration counter width: enough bits to count up to WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One non-restoring division iteration: shift {P,Q} left, add/sub D, set quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   p_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] p_sh;

  // Add/subtract choice uses the sign of P before the shift; the shifted value
  // may wrap in WIDTH+1 bits, but the add/sub brings it back into range.
  always_comb begin
    p_sh      = {p[WIDTH-1:0], q[WIDTH-1]};
    q_next    = {q[WIDTH-2:0], 1'b0};
    p_next    = p[WIDTH] ? (p_sh + {1'b0, d}) : (p_sh - {1'b0, d});
    q_next[0] = ~p_next[WIDTH];
  end

endmodule

// File: rtl/seq_divide.sv
// Multi-cycle signed/unsigned integer divider, one quotient bit per clock.
module seq_divide
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic             qneg;
  logic             rneg;
  logic             dbz_pend;

  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] dd_mag;
  logic [WIDTH-1:0] dv_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p      (p),
    .q      (q),
    .d      (d),
    .p_next (p_next),
    .q_next (q_next)
  );

  // Operand magnitudes at capture and sign/remainder correction at FIX.
  always_comb begin
    dd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dv_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    // True remainder lies in [0, D), so the low WIDTH bits suffice after add-back.
    r_mag  = p[WIDTH] ? (p[WIDTH-1:0] + d) : p[WIDTH-1:0];
    q_fix  = qneg ? -q : q;
    r_fix  = rneg ? -r_mag : r_mag;
  end

  // Control FSM, iteration datapath and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      p           <= '0;
      q           <= '0;
      d           <= '0;
      qneg        <= 1'b0;
      rneg        <= 1'b0;
      dbz_pend    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            p    <= '0;
            d    <= dv_mag;
            qneg <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg <= is_signed && dividend[WIDTH-1];
            if (divisor == '0) begin
              // Q carries the raw dividend through to the remainder output.
              q        <= dividend;
              dbz_pend <= 1'b1;
              state    <= FIX;
            end else begin
              q        <= dd_mag;
              dbz_pend <= 1'b0;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          p   <= p_next;
          q   <= q_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (dbz_pend) begin
            quotient    <= {WIDTH{DBZ_FILL}};
            remainder   <= q;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
